// File: rtl/ifft4_serial.sv
// ifft4_serial: 4-point radix-2 inverse FFT with serial complex input and output.
//   Four frequency bins X0..X3 come in over a valid/ready stream. After one compute
//   cycle, the four time samples x0..x3 go out in index order. Only adders and
//   re/im swaps are used; W^-1 = +j.
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid/in_ready     input handshake; in_data = {re, im}, each DATA_W-bit signed Q16.16
//   out_valid/out_ready   output handshake; out_data = {re, im}
//   out_idx               sample index n (0..3); out_last marks n==3
//
// state   | meaning
// COLLECT | accepting bins X0..X3 into slot cnt
// COMPUTE | all four results computed and registered
// EMIT    | presenting res[idx]; out_valid rises one cycle after entry
module ifft4_serial #(
  parameter int DATA_W   = 32,
  parameter bit SCALE_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*DATA_W-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   out_data,
  output logic [1:0]            out_idx,
  output logic                  out_last
);

  localparam int SW = DATA_W + 3;
  localparam logic signed [SW-1:0] RND  = SW'(2);
  localparam logic signed [SW-1:0] SMAX = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {COLLECT, COMPUTE, EMIT} state_t;

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [1:0] idx, idx_nxt;
  logic       ov, ov_nxt;
  logic       in_xfer;

  logic signed [DATA_W-1:0] bin_re [4];
  logic signed [DATA_W-1:0] bin_im [4];
  logic signed [DATA_W-1:0] res_re [4];
  logic signed [DATA_W-1:0] res_im [4];

  logic signed [SW-1:0] xr [4];
  logic signed [SW-1:0] xi [4];
  logic signed [SW-1:0] sr [4];
  logic signed [SW-1:0] si [4];

  function automatic logic signed [SW-1:0] ext(input logic signed [DATA_W-1:0] v);
    return {{3{v[DATA_W-1]}}, v};
  endfunction

  // Optional /4 with round-half-up, then clamp into the DATA_W range.
  function automatic logic signed [DATA_W-1:0] scale_sat(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] r;
    r = SCALE_EN ? ((s + RND) >>> 2) : s;
    if (r > SMAX)      r = SMAX;
    else if (r < SMIN) r = SMIN;
    return r[DATA_W-1:0];
  endfunction

  assign in_ready  = (state == COLLECT);
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = ov;
  assign out_idx   = idx;
  assign out_last  = ov & (idx == 2'd3);
  assign out_data  = {res_re[idx], res_im[idx]};

  // Butterfly sums; jZ = (-Z.im) + j(Z.re).
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      xr[k] = ext(bin_re[k]);
      xi[k] = ext(bin_im[k]);
    end
    sr[0] = xr[0] + xr[1] + xr[2] + xr[3];
    si[0] = xi[0] + xi[1] + xi[2] + xi[3];
    sr[1] = xr[0] - xi[1] - xr[2] + xi[3];
    si[1] = xi[0] + xr[1] - xi[2] - xr[3];
    sr[2] = xr[0] - xr[1] + xr[2] - xr[3];
    si[2] = xi[0] - xi[1] + xi[2] - xi[3];
    sr[3] = xr[0] + xi[1] - xr[2] - xi[3];
    si[3] = xi[0] - xr[1] - xi[2] + xr[3];
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    ov_nxt    = ov;
    case (state)
      COLLECT: begin
        if (in_xfer) begin
          cnt_nxt = cnt + 2'd1;
          if (cnt == 2'd3) state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        state_nxt = EMIT;
        idx_nxt   = 2'd0;
        ov_nxt    = 1'b0;
      end
      EMIT: begin
        // First EMIT cycle is a bubble so out_valid appears two edges after the last bin.
        if (!ov) begin
          ov_nxt = 1'b1;
        end else if (out_ready) begin
          if (idx == 2'd3) begin
            state_nxt = COLLECT;
            cnt_nxt   = 2'd0;
            idx_nxt   = 2'd0;
            ov_nxt    = 1'b0;
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end
      end
      default: begin
        state_nxt = COLLECT;
        cnt_nxt   = 2'd0;
        idx_nxt   = 2'd0;
        ov_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
      cnt   <= 2'd0;
      idx   <= 2'd0;
      ov    <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        bin_re[k] <= '0;
        bin_im[k] <= '0;
        res_re[k] <= '0;
        res_im[k] <= '0;
      end
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      ov    <= ov_nxt;
      if (in_xfer) begin
        bin_re[cnt] <= in_data[2*DATA_W-1:DATA_W];
        bin_im[cnt] <= in_data[DATA_W-1:0];
      end
      if (state == COMPUTE) begin
        for (int k = 0; k < 4; k++) begin
          res_re[k] <= scale_sat(sr[k]);
          res_im[k] <= scale_sat(si[k]);
        end
      end
    end
  end

endmodule

// File: tb/tb_ifft4_serial.sv
// tb_ifft4_serial: scoreboard bench for ifft4_serial (DATA_W=32, SCALE_EN=1).
//   Expected samples come from a rotation-based IFFT model and are queued when a
//   frame's fourth bin is accepted; a negedge monitor pops them on each output transfer.
module tb_ifft4_serial;

  localparam int DATA_W = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [2*DATA_W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [2*DATA_W-1:0] out_data;
  logic [1:0]         out_idx;
  logic               out_last;

  ifft4_serial #(.DATA_W(DATA_W), .SCALE_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] exp_q[$];
  int          rx_pos = 0;
  int          rx_count = 0;
  int          frames_pushed = 0;
  int          last_in_edge = 0;
  bit          lat_pending = 1'b0;
  bit          hold_pending = 1'b0;
  logic [63:0] held_data;
  logic [1:0]  held_idx;
  int          rdy_mode = 0;
  int          stall_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647)  return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // x[n] = sum X[k] * (+j)^(n*k), then (s+2)>>>2 and saturate.
  function automatic logic [63:0] model(input logic [63:0] b0, input logic [63:0] b1,
                                        input logic [63:0] b2, input logic [63:0] b3,
                                        input int n);
    logic [63:0] b[4];
    longint sr = 0, si = 0, r, i, tr, ti, o_r, o_i;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    for (int k = 0; k < 4; k++) begin
      r = longint'($signed(b[k][63:32]));
      i = longint'($signed(b[k][31:0]));
      case ((n * k) % 4)
        0:       begin tr = r;  ti = i;  end
        1:       begin tr = -i; ti = r;  end
        2:       begin tr = -r; ti = -i; end
        default: begin tr = i;  ti = -r; end
      endcase
      sr += tr;
      si += ti;
    end
    o_r = sat32((sr + 2) >>> 2);
    o_i = sat32((si + 2) >>> 2);
    return {o_r[31:0], o_i[31:0]};
  endfunction

  // Output monitor: values are stable between the falling edge and the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        check_val("no_overlap", 64'(in_ready), 64'(0));
        if (lat_pending) begin
          check_val("latency", 64'(cyc), 64'(last_in_edge + 2));
          lat_pending = 1'b0;
        end
        if (hold_pending) begin
          check_val("hold_data", out_data, held_data);
          check_val("hold_idx", 64'(out_idx), 64'(held_idx));
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check_val("unexpected_out", 64'(1), 64'(0));
          end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check_val("out_data", out_data, e);
            check_val("out_idx", 64'(out_idx), 64'(rx_pos));
            check_val("out_last", 64'(out_last), 64'(rx_pos == 3));
          end
          rx_pos = (rx_pos + 1) % 4;
          rx_count++;
          hold_pending = 1'b0;
        end else begin
          hold_pending = 1'b1;
          held_data = out_data;
          held_idx = out_idx;
        end
      end else begin
        if (hold_pending) check_val("hold_valid", 64'(out_valid), 64'(1));
        hold_pending = 1'b0;
      end
    end
  end

  // out_ready driver: 0 always ready, 1 random, 2 three-cycle stall at idx 1.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: out_ready = ($urandom_range(3, 0) != 0);
        2: begin
          if (out_valid && out_idx == 2'd1 && stall_cnt < 3) begin
            out_ready = 1'b0;
            stall_cnt++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Sends nb bins (nb<4 leaves the frame partial); call at posedge+1.
  task automatic send_bins(input logic [63:0] b0, input logic [63:0] b1,
                           input logic [63:0] b2, input logic [63:0] b3,
                           input int nb, input int gap_max);
    logic [63:0] b[4];
    int t;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    for (int k = 0; k < nb; k++) begin
      if (gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(gap_max, 0)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data = b[k];
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        t++;
        if (t > 200) begin
          check_val("in_ready_timeout", 64'(0), 64'(1));
          finish_test();
        end
      end
      if (gap_max == 0 && k > 0) check_val("b2b_wait", 64'(t), 64'(0));
      @(posedge clk);
      #1;
      if (k == 3) begin
        last_in_edge = cyc;
        lat_pending = 1'b1;
        for (int n = 0; n < 4; n++) exp_q.push_back(model(b0, b1, b2, b3, n));
        frames_pushed++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check_val("drain", 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r0, r1, r2, r3;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    #1;
    check_val("rst_in_ready", 64'(in_ready), 64'(1));
    check_val("rst_out_valid", 64'(out_valid), 64'(0));
    check_val("rst_out_data", out_data, 64'(0));
    check_val("rst_out_idx", 64'(out_idx), 64'(0));
    check_val("rst_out_last", 64'(out_last), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Impulse at X0, then junk held on in_valid during emission.
    send_bins(64'h00040000_00000000, 64'h0, 64'h0, 64'h0, 4, 0);
    in_valid = 1'b1;
    in_data = 64'hDEADBEEF_CAFEF00D;
    begin
      int t = 0;
      while (!(out_valid && out_ready && out_last) && t < 100) begin
        @(negedge clk);
        t++;
      end
      check_val("junk_window", 64'(t < 100), 64'(1));
    end
    in_valid = 1'b0;
    wait_drain();

    // Impulse at X1 -> rotating unit phasor.
    send_bins(64'h0, 64'h00040000_00000000, 64'h0, 64'h0, 4, 0);
    wait_drain();

    // Rounding, positive and negative.
    send_bins(64'h00000006_00000000, 64'h0, 64'h0, 64'h0, 4, 0);
    wait_drain();
    send_bins(64'hFFFFFFFA_00000000, 64'h0, 64'h0, 64'h0, 4, 0);
    wait_drain();

    // Saturation on x2.re.
    send_bins(64'h7FFFFFFF_00000000, 64'h80000000_00000000,
              64'h7FFFFFFF_00000000, 64'h80000000_00000000, 4, 0);
    wait_drain();

    // Backpressure: three-cycle stall at idx 1.
    rdy_mode = 2;
    stall_cnt = 0;
    send_bins(64'h00010000_00020000, 64'hFFFE0000_00030000,
              64'h00050000_FFFF0000, 64'h00000000_00040000, 4, 0);
    wait_drain();
    check_val("stall_done", 64'(stall_cnt), 64'(3));
    rdy_mode = 0;

    // Reset after two accepted bins, then a fresh frame.
    send_bins(64'h11110000_22220000, 64'h33330000_44440000, 64'h0, 64'h0, 2, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("midrst_in_ready", 64'(in_ready), 64'(1));
    check_val("midrst_out_valid", 64'(out_valid), 64'(0));
    rx_pos = 0;
    hold_pending = 1'b0;
    lat_pending = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_bins(64'h00080000_00000000, 64'h00000000_00080000,
              64'hFFF80000_00040000, 64'h00020000_FFFC0000, 4, 0);
    wait_drain();

    // Random frames with random gaps and random out_ready.
    rdy_mode = 1;
    for (int f = 0; f < 8; f++) begin
      r0 = {$urandom, $urandom};
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      r3 = {$urandom, $urandom};
      send_bins(r0, r1, r2, r3, 4, (f % 2 == 0) ? 0 : 2);
      wait_drain();
    end
    rdy_mode = 0;

    check_val("rx_count", 64'(rx_count), 64'(4 * frames_pushed));
    finish_test();
  end

endmodule
